// File: rtl/operand_mem_sched_pkg.sv
// Shared definitions for the operand/memory scheduler.
// Holds the datapath widths, the operand/destination choice encodings,
// the scheduler state type and a small choice-decode helper.
package operand_mem_sched_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int VALUE_WIDTH  = 8;
    localparam int MEM_WIDTH    = 4;

    // Operand / destination source selects; only CHOICE_MEM touches the memory port.
    localparam logic [1:0] CHOICE_REG  = 2'b00;
    localparam logic [1:0] CHOICE_MEM  = 2'b01;
    localparam logic [1:0] CHOICE_IMM  = 2'b10;
    localparam logic [1:0] CHOICE_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_CAP  = 3'd3,
        ST_EXEC = 3'd4,
        ST_WB   = 3'd5,
        ST_DONE = 3'd6
    } sched_state_t;

    function automatic logic is_mem(input logic [1:0] choice);
        return (choice == CHOICE_MEM);
    endfunction

endpackage

// File: rtl/operand_mem_sched.sv
// Operand / memory scheduler sharing one single-port data memory.
// Every accepted instruction runs a fixed schedule:
//   RD1 (src1 read) -> RD2 (capture src1, src2 read) -> CAP (capture src2)
//   -> EXEC (ALU evaluates, result latched) -> WB (optional write) -> DONE.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start + instruction fields   launch request, sampled only in IDLE
//   alu_out                      combinational ALU result of op_q/src1_q/src2_q
//   mem_rdata                    memory read data, one cycle after mem_re
//   mem_addr/mem_re/mem_we/mem_wdata  memory port (zero when no strobe)
//   op_q, src1_q, src2_q, result_q    latched opcode, operands and result
//   operands_valid, busy, done        schedule status
module operand_mem_sched
    import operand_mem_sched_pkg::*;
#(
    parameter int OPCODE_WIDTH = operand_mem_sched_pkg::OPCODE_WIDTH,
    parameter int VALUE_WIDTH  = operand_mem_sched_pkg::VALUE_WIDTH,
    parameter int MEM_WIDTH    = operand_mem_sched_pkg::MEM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic [1:0]              source1_choice,
    input  logic [1:0]              source2_choice,
    input  logic [1:0]              dest_choice,
    input  logic [MEM_WIDTH-1:0]    source1_addr,
    input  logic [MEM_WIDTH-1:0]    source2_addr,
    input  logic [MEM_WIDTH-1:0]    dest_addr,
    input  logic [VALUE_WIDTH-1:0]  src1_ext,
    input  logic [VALUE_WIDTH-1:0]  src2_ext,
    input  logic [VALUE_WIDTH-1:0]  alu_out,
    input  logic [VALUE_WIDTH-1:0]  mem_rdata,
    output logic [MEM_WIDTH-1:0]    mem_addr,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [VALUE_WIDTH-1:0]  mem_wdata,
    output logic [OPCODE_WIDTH-1:0] op_q,
    output logic [VALUE_WIDTH-1:0]  src1_q,
    output logic [VALUE_WIDTH-1:0]  src2_q,
    output logic [VALUE_WIDTH-1:0]  result_q,
    output logic                    operands_valid,
    output logic                    busy,
    output logic                    done
);

    sched_state_t           state_r;
    sched_state_t           next_state_s;

    logic [1:0]             src1_choice_r;
    logic [1:0]             src2_choice_r;
    logic [1:0]             dest_choice_r;
    logic [MEM_WIDTH-1:0]   src1_addr_r;
    logic [MEM_WIDTH-1:0]   src2_addr_r;
    logic [MEM_WIDTH-1:0]   dest_addr_r;
    logic [VALUE_WIDTH-1:0] src1_ext_r;
    logic [VALUE_WIDTH-1:0] src2_ext_r;

    // Next-state logic: fixed one-cycle-per-state walk; start only matters in IDLE.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RD1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD1:  next_state_s = ST_RD2;
            ST_RD2:  next_state_s = ST_CAP;
            ST_CAP:  next_state_s = ST_EXEC;
            ST_EXEC: next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_DONE;
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register plus status flags, registered from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            operands_valid <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            busy           <= (next_state_s != ST_IDLE);
            done           <= (next_state_s == ST_DONE);
            operands_valid <= (next_state_s == ST_EXEC);
        end
    end

    // Instruction, operand and result latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            src1_choice_r <= 2'b00;
            src2_choice_r <= 2'b00;
            dest_choice_r <= 2'b00;
            src1_addr_r   <= '0;
            src2_addr_r   <= '0;
            dest_addr_r   <= '0;
            src1_ext_r    <= '0;
            src2_ext_r    <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            result_q      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_q          <= op_code;
                        src1_choice_r <= source1_choice;
                        src2_choice_r <= source2_choice;
                        dest_choice_r <= dest_choice;
                        src1_addr_r   <= source1_addr;
                        src2_addr_r   <= source2_addr;
                        dest_addr_r   <= dest_addr;
                        src1_ext_r    <= src1_ext;
                        src2_ext_r    <= src2_ext;
                    end
                end
                // Read data for the RD1 request is on mem_rdata during RD2.
                ST_RD2:  src1_q   <= is_mem(src1_choice_r) ? mem_rdata : src1_ext_r;
                ST_CAP:  src2_q   <= is_mem(src2_choice_r) ? mem_rdata : src2_ext_r;
                ST_EXEC: result_q <= alu_out;
                default: ;
            endcase
        end
    end

    // Memory port drive; address/data forced to zero whenever no strobe is active.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_r)
            ST_RD1: begin
                if (is_mem(src1_choice_r)) begin
                    mem_re   = 1'b1;
                    mem_addr = src1_addr_r;
                end else begin
                    mem_re   = 1'b0;
                    mem_addr = '0;
                end
            end
            ST_RD2: begin
                if (is_mem(src2_choice_r)) begin
                    mem_re   = 1'b1;
                    mem_addr = src2_addr_r;
                end else begin
                    mem_re   = 1'b0;
                    mem_addr = '0;
                end
            end
            ST_WB: begin
                if (is_mem(dest_choice_r)) begin
                    mem_we    = 1'b1;
                    mem_addr  = dest_addr_r;
                    mem_wdata = result_q;
                end else begin
                    mem_we    = 1'b0;
                    mem_addr  = '0;
                    mem_wdata = '0;
                end
            end
            default: begin
                mem_re    = 1'b0;
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

endmodule
